// File: rtl/atconv_pkg.sv
// Shared sizes and FSM encoding for the atrous-conv frame scheduler.
package atconv_pkg;

   localparam int ATCONV_DW           = 13;
   localparam int ATCONV_AW           = 12;
   localparam int ATCONV_L1_WORDS     = 1024;
   localparam int ATCONV_L0_WORDS     = 4096;
   localparam int ATCONV_KICK_TIMEOUT = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KICK  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO that catches layer-memory read data (word plus last tag) for the output stream.
module rd_skid_fifo #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] slot0, slot1;
   logic         wr_ptr, rd_ptr;
   logic         push_ok, pop_ok;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push_ok = push && ((count != 2'd2) || pop);
   assign pop_ok  = pop && (count != 2'd0);
   assign head    = rd_ptr ? slot1 : slot0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot0  <= '0;
         slot1  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            if (wr_ptr) slot1 <= push_data;
            else        slot0 <= push_data;
            wr_ptr <= ~wr_ptr;
         end
         if (pop_ok) rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/atconv_frame_sched.sv
// Frame sequencer for the atrous-conv engine: kicks the engine, flags a hung engine, then streams the
// layer-memory words to the host. Define ATCONV_DUMP_L0_EN to stream layer 0 ahead of layer 1.
module atconv_frame_sched
   import atconv_pkg::*;
#(
   parameter int DW           = ATCONV_DW,
   parameter int AW           = ATCONV_AW,
   parameter int L1_WORDS     = ATCONV_L1_WORDS,
   parameter int L0_WORDS     = ATCONV_L0_WORDS,
   parameter int KICK_TIMEOUT = ATCONV_KICK_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic          err,
   output logic          eng_ready,
   input  logic          eng_busy,
   output logic          mem_own,
   output logic          csel,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic [2:0]    state_dbg
);

`ifdef ATCONV_DUMP_L0_EN
   localparam int TOTAL = L0_WORDS + L1_WORDS;
`else
   localparam int TOTAL = L1_WORDS;
`endif
   // One counter width serves both builds so the address logic is identical in each.
   localparam int CW = $clog2(L0_WORDS + L1_WORDS + 1);
   localparam int KW = $clog2(KICK_TIMEOUT + 1);
   localparam logic [CW-1:0] ISSUE_END  = CW'(TOTAL);
   localparam logic [CW-1:0] ISSUE_LAST = CW'(TOTAL - 1);
   localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_TIMEOUT - 1);

   sched_state_t    state, state_nxt;
   logic            busy_q;
   logic [KW-1:0]   kick_cnt;
   logic [CW-1:0]   issue_cnt;
   logic            inflight, inflight_last;
   logic            err_q;
   logic            kick_expire;
   logic            l1_phase;
   logic            push, pop;
   logic [DW:0]     head;
   logic [1:0]      fifo_cnt;
   logic [2:0]      pending;

   // Stream handshake: a word moves when m_valid and m_ready are both high on a rising edge;
   // m_valid never drops and m_data/m_last never change until that happens.
   assign m_valid = (fifo_cnt != 2'd0);
   assign pop     = m_valid & m_ready;
   assign m_data  = head[DW-1:0];
   assign m_last  = m_valid & head[DW];
   assign push    = inflight;

   assign kick_expire = (state == KICK) && !eng_busy && (kick_cnt == KICK_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = KICK;
         KICK: begin
            if (eng_busy)         state_nxt = RUN;
            else if (kick_expire) state_nxt = DONE;
         end
         RUN:   if (busy_q && !eng_busy) state_nxt = DRAIN;
         DRAIN: if (pop && m_last) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      eng_ready = 1'b0;
      mem_own   = 1'b0;
      done      = 1'b0;
      case (state)
         KICK:    eng_ready = 1'b1;
         DRAIN:   mem_own   = 1'b1;
         DONE:    done      = 1'b1;
         default: ;
      endcase
   end

   // Slots that will be taken once this cycle's pop retires; issuing against this keeps one word/cycle.
   assign pending = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign crd     = mem_own && (issue_cnt < ISSUE_END) && (pending < 3'd2);

`ifdef ATCONV_DUMP_L0_EN
   localparam logic [CW-1:0] L0_END = CW'(L0_WORDS);
   assign l1_phase = (issue_cnt >= L0_END);
   assign caddr_rd = l1_phase ? AW'(issue_cnt - L0_END) : AW'(issue_cnt);
`else
   assign l1_phase = 1'b1;
   assign caddr_rd = AW'(issue_cnt);
`endif
   assign csel = mem_own & l1_phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q        <= 1'b0;
         kick_cnt      <= '0;
         issue_cnt     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         busy_q <= eng_busy;
         if (state == KICK) kick_cnt <= kick_cnt + 1'b1;
         else               kick_cnt <= '0;
         if (state == IDLE && start) err_q <= 1'b0;
         else if (kick_expire)       err_q <= 1'b1;
         if (state != DRAIN) issue_cnt <= '0;
         else if (crd)       issue_cnt <= issue_cnt + 1'b1;
         inflight      <= crd;
         inflight_last <= crd && (issue_cnt == ISSUE_LAST);
      end
   end

   rd_skid_fifo #(.W(DW + 1)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({inflight_last, cdata_rd}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_cnt)
   );

   assign err       = err_q;
   assign state_dbg = state;

endmodule
